// File: rtl/inst_cache_ctrl_pkg.sv
// Shared types and helpers for the direct-mapped instruction cache controller.
package inst_cache_ctrl_pkg;

    localparam int unsigned DataWidth = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRefill = 2'd1,
        StDone   = 2'd2
    } state_e;

    function automatic int unsigned line_words(input int unsigned word_bits);
        return 32'd1 << word_bits;
    endfunction

    // Tag is whatever remains above index, word select and byte offset.
    function automatic int unsigned tag_width(input int unsigned addr_width,
                                              input int unsigned index_bits,
                                              input int unsigned word_bits);
        return addr_width - index_bits - word_bits - 2;
    endfunction

endpackage

// File: rtl/inst_cache_ctrl_if.sv
// Fetch-side and refill-side bus of the instruction cache.
interface inst_cache_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    import inst_cache_ctrl_pkg::*;

    logic                  cpu_ren;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DataWidth-1:0]  cpu_data;
    logic                  cpu_stall;
    logic                  mem_cs;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DataWidth-1:0]  mem_data;

    // slave: the cache itself; master: the fetch stage and memory around it.
    modport slave (
        input  cpu_ren, cpu_addr, mem_ack, mem_data,
        output cpu_data, cpu_stall, mem_cs, mem_addr
    );

    modport master (
        output cpu_ren, cpu_addr, mem_ack, mem_data,
        input  cpu_data, cpu_stall, mem_cs, mem_addr
    );

endinterface

// File: rtl/inst_cache_ctrl_line_ram.sv
// Tag and data storage: asynchronous read by index/word, one-word synchronous write per cycle.
module inst_cache_ctrl_line_ram
    import inst_cache_ctrl_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned WORD_BITS  = 2,
    parameter int unsigned TAG_WIDTH  = 22
) (
    input  logic                  clk_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    input  logic [WORD_BITS-1:0]  rd_word_i,
    output logic [TAG_WIDTH-1:0]  rd_tag_o,
    output logic [DataWidth-1:0]  rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [WORD_BITS-1:0]  wr_word_i,
    input  logic [DataWidth-1:0]  wr_data_i,
    input  logic                  tag_we_i,
    input  logic [TAG_WIDTH-1:0]  wr_tag_i
);

    localparam int unsigned Lines = 1 << INDEX_BITS;
    localparam int unsigned Words = line_words(WORD_BITS);

    logic [TAG_WIDTH-1:0] tag_q  [Lines];
    logic [DataWidth-1:0] data_q [Lines][Words];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            data_q[wr_index_i][wr_word_i] <= wr_data_i;
        end
        if (tag_we_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    assign rd_tag_o  = tag_q[rd_index_i];
    assign rd_data_o = data_q[rd_index_i][rd_word_i];

endmodule

// File: rtl/inst_cache_ctrl.sv
// Direct-mapped read-only instruction cache: zero-latency hit, word-by-word line refill on miss.
module inst_cache_ctrl
    import inst_cache_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 6,
    parameter int unsigned WORD_BITS  = 2,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    inst_cache_ctrl_if.slave      bus_io,
    input  logic                  inv_all_i,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

    localparam int unsigned TagWidth = tag_width(ADDR_WIDTH, INDEX_BITS, WORD_BITS);
    localparam int unsigned Lines    = 1 << INDEX_BITS;
    localparam int unsigned WordLsb  = 2;
    localparam int unsigned IndexLsb = WORD_BITS + 2;
    localparam int unsigned TagLsb   = INDEX_BITS + WORD_BITS + 2;

    logic [WORD_BITS-1:0]  cpu_word;
    logic [INDEX_BITS-1:0] cpu_index;
    logic [TagWidth-1:0]   cpu_tag;
    logic                  unused_addr_bits;

    assign cpu_word         = bus_io.cpu_addr[IndexLsb-1:WordLsb];
    assign cpu_index        = bus_io.cpu_addr[TagLsb-1:IndexLsb];
    assign cpu_tag          = bus_io.cpu_addr[ADDR_WIDTH-1:TagLsb];
    assign unused_addr_bits = ^bus_io.cpu_addr[1:0];

    state_e                state_q, state_d;
    logic [Lines-1:0]      valid_q, valid_d;
    logic [WORD_BITS-1:0]  cnt_q, cnt_d;
    logic [TagWidth-1:0]   miss_tag_q, miss_tag_d;
    logic [INDEX_BITS-1:0] miss_index_q, miss_index_d;
    logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

    logic [TagWidth-1:0]   rd_tag;
    logic [DataWidth-1:0]  rd_data;
    logic                  ram_we;
    logic                  tag_we;
    logic                  hit;

    logic [DataWidth-1:0]  cpu_data;
    logic                  cpu_stall;
    logic                  mem_cs;
    logic [ADDR_WIDTH-1:0] mem_addr;

    inst_cache_ctrl_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS),
        .TAG_WIDTH  (TagWidth)
    ) u_line_ram (
        .clk_i      (clk),
        .rd_index_i (cpu_index),
        .rd_word_i  (cpu_word),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (ram_we),
        .wr_index_i (miss_index_q),
        .wr_word_i  (cnt_q),
        .wr_data_i  (bus_io.mem_data),
        .tag_we_i   (tag_we),
        .wr_tag_i   (miss_tag_q)
    );

    assign hit = bus_io.cpu_ren & valid_q[cpu_index] & (rd_tag == cpu_tag);

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        cnt_d        = cnt_q;
        miss_tag_d   = miss_tag_q;
        miss_index_d = miss_index_q;
        miss_cnt_d   = miss_cnt_q;
        cpu_data     = '0;
        cpu_stall    = 1'b0;
        mem_cs       = 1'b0;
        mem_addr     = '0;
        ram_we       = 1'b0;
        tag_we       = 1'b0;

        // Invalidate first so a line finishing in StDone still ends up valid.
        if (inv_all_i) begin
            valid_d = '0;
        end

        unique case (state_q)
            StIdle: begin
                if (hit) begin
                    cpu_data = rd_data;
                end else if (bus_io.cpu_ren) begin
                    cpu_stall    = 1'b1;
                    miss_tag_d   = cpu_tag;
                    miss_index_d = cpu_index;
                    cnt_d        = '0;
                    if (miss_cnt_q != '1) begin
                        miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                    state_d = StRefill;
                end
            end
            StRefill: begin
                mem_cs    = 1'b1;
                mem_addr  = {miss_tag_q, miss_index_q, cnt_q, 2'b00};
                cpu_stall = 1'b1;
                if (bus_io.mem_ack) begin
                    ram_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                cpu_stall             = 1'b1;
                tag_we                = 1'b1;
                valid_d[miss_index_q] = 1'b1;
                state_d               = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            valid_q      <= '0;
            cnt_q        <= '0;
            miss_tag_q   <= '0;
            miss_index_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            miss_tag_q   <= miss_tag_d;
            miss_index_q <= miss_index_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign bus_io.cpu_data  = cpu_data;
    assign bus_io.cpu_stall = cpu_stall;
    assign bus_io.mem_cs    = mem_cs;
    assign bus_io.mem_addr  = mem_addr;
    assign miss_cnt_o       = miss_cnt_q;

endmodule

// File: doc/inst_cache_ctrl.md
Name: inst_cache_ctrl

Overview:
- Direct-mapped, read-only instruction cache between the IF stage and the instruction memory bus.
- The IF stage consumes cpu_stall as its inst_stall input. The pipeline controller responds by holding IF/ID and flushing EXE.
- On a miss the block refills one line from memory with a word-by-word req/ack handshake, then replays the lookup.
- Also keeps a saturating miss counter for debug display.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- INDEX_BITS, 6, log2 of the number of lines (64 lines).
- WORD_BITS, 2, log2 of words per line (4 words, 16 bytes).
- CNT_WIDTH, 16, miss counter width.

Ports:
- clk  in  1  main clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_ren  in  1  fetch request valid.
- cpu_addr  in  ADDR_WIDTH  fetch byte address (PC); bits [1:0] ignored.
- cpu_data  out  32  instruction word.
- cpu_stall  out  1  fetch not satisfied this cycle.
- inv_all  in  1  synchronous invalidate of all lines.
- mem_cs  out  1  memory word request.
- mem_addr  out  ADDR_WIDTH  word-aligned refill address.
- mem_ack  in  1  mem_data valid for the current request.
- mem_data  in  32  refill word.
- miss_cnt  out  CNT_WIDTH  number of misses since reset, saturating.

Behaviour:
- Address split: offset [1:0], word [WORD_BITS+1:2], index [INDEX_BITS+WORD_BITS+1:WORD_BITS+2], tag = remaining upper bits.
- Storage: valid bits are flops, cleared asynchronously by rst_n. Tag and data arrays carry no reset.
- FSM states and encoding: S_IDLE 2'd0, S_REFILL 2'd1, S_DONE 2'd2.
- Reset values: state=S_IDLE, all valid=0, word counter=0, miss_cnt=0, mem_cs=0, mem_addr=0, cpu_stall=0, cpu_data=0.
- S_IDLE:
  - hit = cpu_ren & valid[index] & tag match.
  - On hit: cpu_data = the selected word, combinationally in the same cycle (zero-cycle latency); cpu_stall=0.
  - On miss with cpu_ren=1: cpu_stall=1 combinationally; latch miss tag and index; word counter=0; miss_cnt += 1 unless at all-ones; next state S_REFILL.
  - cpu_ren=0: cpu_stall=0, cpu_data=0, no state change.
- S_REFILL:
  - mem_cs=1; mem_addr = {latched tag, latched index, counter, 2'b00}; cpu_stall=1.
  - Each cycle with mem_ack=1: write mem_data into word[counter] of the latched line; counter += 1.
  - If the ack was for the last word (counter = all-ones), next state S_DONE.
  - mem_ack may be high in the same cycle mem_cs first rises. Wait states of any length are allowed.
- S_DONE: mem_cs=0; cpu_stall=1; set valid and tag for the latched index; next state S_IDLE, where the lookup replays.
- Zero-wait memory: a miss costs exactly 2^WORD_BITS + 2 stall cycles (6 at defaults). The first non-stalled cycle returns the refilled word.
- Refill always fetches words 0..N-1 in order. There is no critical-word-first.
- The lookup in S_IDLE after S_DONE uses the current cpu_addr. If the PC changed meanwhile, the lookup may miss again, which is correct behaviour.
- inv_all:
  - In S_IDLE: clears all valid bits at the clock edge. A hit reported in that same cycle stands.
  - In S_REFILL/S_DONE: clears all valid bits. The in-flight line still completes and becomes valid in S_DONE.
- rst_n low mid-refill: immediate return to S_IDLE, mem_cs drops asynchronously, all lines invalid. No partial line may later report a hit.
- miss_cnt saturates at 2^CNT_WIDTH-1 and does not wrap.

Decomposition:
- Shared package/header (icache_define.vh alongside the existing define headers): state encodings S_IDLE/S_REFILL/S_DONE, LINE_WORDS = 1<<WORD_BITS, tag-width derivation macro.
- One sub-module, icache_line_ram:
  - tag+data storage, INDEX_BITS-deep;
  - asynchronous read by index and word;
  - synchronous write of one word per cycle, plus a tag-write strobe.
- Valid bits and the FSM stay in the top module.

Test Plan:
1. Reset, then cpu_ren=1, cpu_addr=0x00000010, memory returns 0xA0000000+word with ack every cycle. Required:
   - cpu_stall high for exactly 6 cycles;
   - mem_addr sequence 0x10, 0x14, 0x18, 0x1C;
   - cpu_data=0xA0000000 at the first unstalled cycle;
   - miss_cnt=1.
2. After test 1, fetch 0x14, 0x18, 0x1C. Required: cpu_stall=0, data words 1..3 in the same cycle, miss_cnt unchanged.
3. Conflict miss: fetch 0x00000410, which has the same index as 0x10 and a different tag. Required: refill, then a refetch of 0x10 misses again; miss_cnt=3.
4. mem_ack held low for 3 cycles before each word. Required: stall lasts 4*4+2 = 18 cycles; mem_addr held stable during each wait.
5. rst_n pulsed low during the 2nd refill word. Required: mem_cs=0 immediately; refetch of the same address misses and fully refills; miss_cnt restarts at 1.
6. inv_all pulsed in S_IDLE after a line is cached. Required: the next fetch of that line misses. Also: with 2^CNT_WIDTH forced misses, miss_cnt stays at all-ones.
